udp_rx_arbiter: RTL and testbench
=================================

Name: udp_rx_arbiter

Overview:
- Shares the single UDP receiver datapath between two ingress requesters, each presenting 64-bit frame words.
- Grants one requester per whole frame using round-robin order.
- Sequences the frame through header, length/checksum and payload phases, and checks the beat count against the UDP length field.
- Aborts stalled frames on timeout. Sits directly in front of the receiver's 64-bit input.

Parameters:
- DATA_W, 64, word width; fixed frame layout below requires 64.
- TIMEOUT, 255, consecutive mid-frame idle cycles (valid low) before abort; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 word valid.
- req0_data  in  64  requester 0 word.
- req0_last  in  1  requester 0 final word of frame.
- req0_ready  out  1  requester 0 word accepted when valid&ready.
- req1_valid  in  1  requester 1 word valid.
- req1_data  in  64  requester 1 word.
- req1_last  in  1  requester 1 final word of frame.
- req1_ready  out  1  requester 1 word accepted when valid&ready.
- rx_valid  out  1  word valid to receiver.
- rx_data  out  64  word to receiver.
- rx_sof  out  1  current rx word is word0 (ports).
- rx_last  out  1  current rx word is final.
- rx_abort  out  1  one-cycle pulse; receiver discards the partial frame.
- rx_ready  in  1  receiver accepts word.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  frame in progress.
- len_err  out  1  one-cycle pulse at frame end on beat-count mismatch.
- timeout_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Frame layout:
  - word0: [31:16] src port, [15:0] dst port.
  - word1: [31:16] UDP length L (bytes, includes 8-byte header), [15:0] checksum.
  - Then payload words; [63:32] of word0/word1 are passed through unchecked.
- Expected beats E = 2 + ((L-8+7)>>3) for L>=8. For L<8, E=2 and len_err is forced at frame end.
- Arithmetic is 16-bit unsigned. The beat counter is 16 bits and saturates at 0xFFFF.
- States:
  - IDLE: grant=00. If any req valid, pick winner, register grant, go HDR. Arbitration costs one cycle; no word is transferred in IDLE.
  - HDR: word0 transfer, rx_sof=1.
  - LEN: word1 transfer; latch L, compute E.
  - PAY: remaining words.
- Any state: an accepted word with last=1 goes to IDLE.
- Round-robin: a pointer names the preferred requester. It flips to the other requester after each completed or aborted frame. If only one requester is valid, it wins regardless of the pointer. After reset the pointer prefers req0.
- Datapath (combinational pass-through in HDR/LEN/PAY):
  - rx_valid = granted valid; rx_data = granted data; rx_last = granted last.
  - granted ready = rx_ready; the non-granted ready is 0.
  - In IDLE all readies are 0 and rx_valid is 0.
- Transfer is valid&ready. State advances only on a transfer.
- Frame ending in HDR or LEN (last on word0/word1) is legal-but-short and pulses len_err.
- At the last transfer, the beat count (including this word) is compared to E. On mismatch, len_err pulses in the cycle after the last transfer.
- Timeout:
  - In HDR/LEN/PAY the counter increments each cycle the granted valid is low and clears on valid high.
  - When it reaches TIMEOUT: timeout_err and rx_abort pulse for one cycle, grant is released, pointer flips, state goes to IDLE.
  - A stalled rx_ready (valid high) never times out.
- busy=1 in HDR/LEN/PAY.
- Reset (async, any time, including mid-frame):
  - state IDLE, grant=00, pointer=req0, counters 0.
  - All outputs 0: readies, rx_valid, rx_sof, rx_last, rx_abort, busy, len_err, timeout_err; rx_data=0.
  - No abort pulse is issued on reset.

Test Plan:
- req0 only: {0x000a0003, 0x0040c842, 7 payload words, last on 7th}, rx_ready=1 → grant=01 one cycle after valid; 9 transfers; rx_sof on word0; no len_err; grant=00 after last.
- Both valid continuously from reset, each sending a 3-word frame with L=0x0010 → order req0, req1, req0; each frame preceded by one idle arbitration cycle; the non-granted ready stays 0.
- req1 frame with L=0x0040 but last on the 5th word → len_err pulses one cycle after the 5th transfer; state returns to IDLE.
- Frame L=0x0004, last on word1 → len_err pulse.
- TIMEOUT=4: req0 sends word0, then valid low → timeout_err and rx_abort pulse 4 cycles later; next grant goes to req1 if valid.
- rx_ready held low 300 cycles mid-frame with valid high → no timeout; frame completes normally. Assert rst mid-PAY → all outputs 0 immediately, grant=00.

Source files
------------

// File: rtl/udp_rx_arbiter.sv
// rtl/udp_rx_arbiter.sv - round-robin frame arbiter in front of the 64-bit UDP receiver
module udp_rx_arbiter #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_sof,
    output logic              rx_last,
    output logic              rx_abort,
    input  logic              rx_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              len_err,
    output logic              timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_LEN, ST_PAY} state_t;

    // The idle counter fires on the cycle it would have reached TIMEOUT.
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t            state;
    logic              ptr;
    logic [15:0]       beat_cnt;
    logic [15:0]       exp_beats;
    logic              len_short;
    logic [7:0]        idle_cnt;

    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic [15:0]       beats_now;
    logic [15:0]       frame_len;

    // Route the granted requester onto the receiver; nothing passes while idle.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        if (busy) begin
            if (grant[1]) begin
                g_valid = req1_valid;
                g_last  = req1_last;
                g_data  = req1_data;
            end else begin
                g_valid = req0_valid;
                g_last  = req0_last;
                g_data  = req0_data;
            end
        end
    end

    assign rx_valid   = g_valid;
    assign rx_data    = g_data;
    assign rx_last    = g_last;
    assign rx_sof     = (state == ST_HDR);
    assign req0_ready = busy & grant[0] & rx_ready;
    assign req1_ready = busy & grant[1] & rx_ready;

    // Beat count including the word on the bus, saturating so huge frames still mismatch cleanly.
    assign beats_now = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
    assign frame_len = g_data[31:16];

    // Frame sequencer: arbitration, phase tracking, length check and stall timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= 2'b00;
            busy        <= 1'b0;
            ptr         <= 1'b0;
            beat_cnt    <= 16'd0;
            exp_beats   <= 16'd0;
            len_short   <= 1'b0;
            idle_cnt    <= 8'd0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            rx_abort    <= 1'b0;
        end else begin
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            rx_abort    <= 1'b0;
            if (state == ST_IDLE) begin
                if (req0_valid || req1_valid) begin
                    grant    <= (req0_valid && (!req1_valid || !ptr)) ? 2'b01 : 2'b10;
                    busy     <= 1'b1;
                    state    <= ST_HDR;
                    beat_cnt <= 16'd0;
                    idle_cnt <= 8'd0;
                end
            end else if (!g_valid) begin
                if (idle_cnt == IDLE_LIMIT) begin
                    timeout_err <= 1'b1;
                    rx_abort    <= 1'b1;
                    grant       <= 2'b00;
                    busy        <= 1'b0;
                    ptr         <= ~ptr;
                    idle_cnt    <= 8'd0;
                    state       <= ST_IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end else begin
                idle_cnt <= 8'd0;
                if (rx_ready) begin
                    beat_cnt <= beats_now;
                    if (g_last) begin
                        // Frames ending before payload are always short.
                        len_err <= (state != ST_PAY) || len_short || (beats_now != exp_beats);
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                        ptr     <= ~ptr;
                        state   <= ST_IDLE;
                    end else if (state == ST_HDR) begin
                        state <= ST_LEN;
                    end else if (state == ST_LEN) begin
                        exp_beats <= ((frame_len - 16'd1) >> 3) + 16'd2;
                        len_short <= (frame_len < 16'd8);
                        state     <= ST_PAY;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_arbiter.sv
// tb/tb_udp_rx_arbiter.sv - randomized self-checking bench for udp_rx_arbiter
module tb_udp_rx_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic [63:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, rx_valid, rx_sof, rx_last, rx_abort;
    logic        rx_ready = 1'b0;
    logic [63:0] rx_data;
    logic [1:0]  grant;
    logic        busy, len_err, timeout_err;

    always #5 clk = ~clk;

    udp_rx_arbiter #(.DATA_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof), .rx_last(rx_last),
        .rx_abort(rx_abort), .rx_ready(rx_ready), .grant(grant), .busy(busy),
        .len_err(len_err), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pending words per requester, whole frames only.
    logic [63:0] qd0[$], qd1[$];
    bit          ql0[$], ql1[$];
    int gap_pct = 0, rdy_pct = 100;
    int lo0 = 0, lo1 = 0;

    // Reference model: who owns the receiver, where we are in the frame, what the length field said.
    int owner = -1;
    bit mptr = 1'b0;
    int beat = 0;
    int lm = 0;
    bit exp_le = 1'b0;
    int le_seen = 0, frames_done = 0;
    int order[$];

    task automatic push_word(int r, logic [63:0] w, bit l);
        if (r == 0) begin qd0.push_back(w); ql0.push_back(l); end
        else        begin qd1.push_back(w); ql1.push_back(l); end
    endtask

    task automatic push_frame(int r, int n, logic [15:0] len);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if (i == 1) w[31:16] = len;
            push_word(r, w, i == n - 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
        req0_data = '0; req1_data = '0; rx_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        qd0.delete(); qd1.delete(); ql0.delete(); ql1.delete();
        owner = -1; mptr = 0; beat = 0; exp_le = 0; lo0 = 0; lo1 = 0;
    endtask

    // One clock: drive at the falling edge, check the DUT against the model, advance the model.
    task automatic step();
        bit v0, v1, rr, ov, lst, err;
        logic [63:0] w;
        logic [1:0] eg;
        @(negedge clk);
        v0 = (qd0.size() > 0) && (lo0 >= 2 || $urandom_range(99) >= gap_pct);
        v1 = (qd1.size() > 0) && (lo1 >= 2 || $urandom_range(99) >= gap_pct);
        lo0 = v0 ? 0 : lo0 + 1;
        lo1 = v1 ? 0 : lo1 + 1;
        rr = $urandom_range(99) < rdy_pct;
        req0_valid = v0; req0_data = v0 ? qd0[0] : 64'd0; req0_last = v0 ? ql0[0] : 1'b0;
        req1_valid = v1; req1_data = v1 ? qd1[0] : 64'd0; req1_last = v1 ? ql1[0] : 1'b0;
        rx_ready = rr;
        #1;
        n_cmp++;
        if (len_err !== exp_le) begin n_bad++; $display("FAIL len_err: got %b want %b", len_err, exp_le); end
        if (len_err === 1'b1) le_seen++;
        n_cmp++;
        if ({timeout_err, rx_abort} !== 2'b00) begin
            n_bad++; $display("FAIL no_abort: got %b%b want 00", timeout_err, rx_abort);
        end
        eg = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
        n_cmp++;
        if ({grant, busy} !== {eg, owner >= 0}) begin
            n_bad++; $display("FAIL grant_busy: got %b/%b want %b/%b", grant, busy, eg, owner >= 0);
        end
        exp_le = 1'b0;
        if (owner < 0) begin
            n_cmp++;
            if ({req1_ready, req0_ready, rx_valid} !== 3'b000) begin
                n_bad++; $display("FAIL idle_quiet: got r1=%b r0=%b v=%b want 000", req1_ready, req0_ready, rx_valid);
            end
            if (v0 || v1) begin
                owner = (v0 && v1) ? int'(mptr) : (v0 ? 0 : 1);
                beat = 0;
                order.push_back(owner);
            end
        end else begin
            ov = (owner == 0) ? v0 : v1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== ((owner == 0) ? {1'b0, rr} : {rr, 1'b0})) begin
                n_bad++; $display("FAIL readies: got r1=%b r0=%b owner=%0d rx_ready=%b", req1_ready, req0_ready, owner, rr);
            end
            n_cmp++;
            if (rx_valid !== ov) begin n_bad++; $display("FAIL rx_valid: got %b want %b", rx_valid, ov); end
            if (ov) begin
                w   = (owner == 0) ? qd0[0] : qd1[0];
                lst = (owner == 0) ? ql0[0] : ql1[0];
                n_cmp++;
                if ({rx_data, rx_last, rx_sof} !== {w, lst, beat == 0}) begin
                    n_bad++;
                    $display("FAIL rx_word: got %h last=%b sof=%b want %h last=%b sof=%b",
                             rx_data, rx_last, rx_sof, w, lst, beat == 0);
                end
                if (rr) begin
                    if (owner == 0) begin void'(qd0.pop_front()); void'(ql0.pop_front()); end
                    else            begin void'(qd1.pop_front()); void'(ql1.pop_front()); end
                    beat++;
                    if (beat == 2) lm = int'(w[31:16]);
                    if (lst) begin
                        err = (beat < 3) || (lm < 8) || (beat != 2 + (lm - 1) / 8);
                        exp_le = err;
                        owner = -1;
                        mptr = ~mptr;
                        frames_done++;
                    end
                end
            end
        end
    endtask

    task automatic run(int max_cycles);
        int c;
        c = 0;
        while (qd0.size() > 0 || qd1.size() > 0 || owner >= 0 || exp_le) begin
            if (c >= max_cycles) begin
                n_cmp++; n_bad++;
                $display("FAIL drain_timeout: still busy after %0d cycles, want drained", c);
                break;
            end
            step();
            c++;
        end
        step();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, rx_valid, rx_sof, rx_last, rx_abort, busy, len_err, timeout_err} !== 9'd0
            || grant !== 2'b00 || rx_data !== 64'd0) begin
            n_bad++; $display("FAIL reset_outputs: got grant=%b busy=%b rx_valid=%b want all zero", grant, busy, rx_valid);
        end
        do_reset();
    endtask

    task automatic test_single_req0();
        int f0;
        f0 = frames_done;
        gap_pct = 0; rdy_pct = 100;
        push_word(0, 64'h0000_0000_000a_0003, 0);
        push_word(0, 64'h0000_0000_0040_c842, 0);
        for (int i = 0; i < 7; i++) push_word(0, {$urandom, $urandom}, i == 6);
        order.delete();
        run(100);
        n_cmp++;
        if (frames_done - f0 !== 1 || order.size() != 1 || order[0] != 0) begin
            n_bad++; $display("FAIL single_req0: got frames=%0d owners=%0d want 1 frame from req0", frames_done - f0, order.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        gap_pct = 0; rdy_pct = 100;
        push_frame(0, 3, 16'h0010);
        push_frame(0, 3, 16'h0010);
        push_frame(1, 3, 16'h0010);
        order.delete();
        run(100);
        n_cmp++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            n_bad++; $display("FAIL rr_order: got %0d grants first=%0d want order 0,1,0", order.size(),
                              order.size() > 0 ? order[0] : -1);
        end
    endtask

    task automatic test_len_err();
        int l0;
        l0 = le_seen;
        gap_pct = 0; rdy_pct = 100;
        push_frame(1, 5, 16'h0040);
        run(100);
        push_frame(0, 2, 16'h0004);
        run(100);
        n_cmp++;
        if (le_seen - l0 != 2) begin
            n_bad++; $display("FAIL len_err_count: got %0d pulses want 2", le_seen - l0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        rx_ready = 1;
        req0_valid = 1; req0_data = 64'h0000_0000_000a_0003; req0_last = 0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (grant !== 2'b01 || req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL to_grant: got grant=%b ready=%b want 01/1", grant, req0_ready);
        end
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_data = 64'h0000_0000_1111_2222; req1_last = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({timeout_err, rx_abort} !== ((k == 4) ? 2'b11 : 2'b00)) begin
                n_bad++; $display("FAIL to_pulse: idle cycle %0d got %b%b want %b", k, timeout_err, rx_abort, k == 4);
            end
            if (k == 4) begin
                n_cmp++;
                if ({grant, busy} !== 3'b000) begin n_bad++; $display("FAIL to_release: got %b/%b want 00/0", grant, busy); end
            end
        end
        n_cmp++;
        if (grant !== 2'b10) begin n_bad++; $display("FAIL to_next_grant: got %b want 10", grant); end
        do_reset();
    endtask

    task automatic test_stall_and_reset();
        int f0, l0, c;
        f0 = frames_done; l0 = le_seen;
        gap_pct = 0; rdy_pct = 100;
        push_frame(0, 9, 16'h0040);
        c = 0;
        while (beat < 3 && c < 20) begin step(); c++; end
        rdy_pct = 0;
        repeat (300) step();
        rdy_pct = 100;
        run(100);
        n_cmp++;
        if (frames_done - f0 != 1 || le_seen != l0) begin
            n_bad++; $display("FAIL stall_complete: got frames=%0d len_errs=%0d want 1/0", frames_done - f0, le_seen - l0);
        end
        push_frame(1, 9, 16'h0040);
        c = 0;
        while (beat < 3 && c < 20) begin step(); c++; end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready, rx_valid, rx_sof, rx_last, rx_abort, busy, len_err, timeout_err} !== 9'd0
            || grant !== 2'b00 || rx_data !== 64'd0) begin
            n_bad++; $display("FAIL midframe_reset: got grant=%b busy=%b rx_valid=%b rx_abort=%b want all zero",
                              grant, busy, rx_valid, rx_abort);
        end
        do_reset();
    endtask

    task automatic test_random();
        int f0, n;
        logic [15:0] len;
        f0 = frames_done;
        gap_pct = 30; rdy_pct = 70;
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(1, 8);
            if (n >= 3 && $urandom_range(1) == 1) len = 16'(8 + 8 * (n - 2) - int'($urandom_range(0, 7)));
            else len = 16'($urandom_range(0, 80));
            push_frame($urandom_range(1), n, len);
        end
        run(4000);
        n_cmp++;
        if (frames_done - f0 != 24) begin
            n_bad++; $display("FAIL random_frames: got %0d want 24", frames_done - f0);
        end
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_round_robin();
        test_len_err();
        test_timeout();
        test_stall_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
